// File: rtl/mem_arbiter.sv
// Single-port bus arbiter between instruction fetch and data access; data wins,
// one transaction outstanding, results held until the whole pipeline advances.
//
// state  | meaning
// IDLE   | no transaction in flight; picks data first, then fetch
// D_REQ  | data request driven on the bus, waiting for addr_ok
// D_WAIT | data address accepted, waiting for data_ok
// I_REQ  | fetch request driven on the bus, waiting for addr_ok
// I_WAIT | fetch address accepted, waiting for data_ok
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          i_stall,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          d_stall,
  input  logic          ext_stall,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT} st_t;

  st_t           st;
  logic          inst_done;
  logic          data_done;
  logic [DW-1:0] inst_rdata_r;
  logic [DW-1:0] data_rdata_r;
  logic          adv;

  assign i_stall    = inst_req & ~inst_done;
  assign d_stall    = data_req & ~data_done;
  assign adv        = ~i_stall & ~d_stall & ~ext_stall;
  assign inst_rdata = inst_rdata_r;
  assign data_rdata = data_rdata_r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st           <= IDLE;
      inst_done    <= 1'b0;
      data_done    <= 1'b0;
      inst_rdata_r <= '0;
      data_rdata_r <= '0;
      bus_req      <= 1'b0;
      bus_wr       <= 1'b0;
      bus_size     <= 2'd0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
    end else begin
      // Done flags survive stalls from the other requester or the divider.
      if (adv) begin
        inst_done <= 1'b0;
        data_done <= 1'b0;
      end
      case (st)
        IDLE: begin
          if (d_stall) begin
            bus_req   <= 1'b1;
            bus_wr    <= data_wr;
            bus_size  <= data_size;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            st        <= D_REQ;
          end else if (i_stall) begin
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd2;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
            st        <= I_REQ;
          end
        end
        D_REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              data_rdata_r <= bus_rdata;
              data_done    <= 1'b1;
              st           <= IDLE;
            end else begin
              st <= D_WAIT;
            end
          end
        end
        D_WAIT: begin
          if (bus_data_ok) begin
            data_rdata_r <= bus_rdata;
            data_done    <= 1'b1;
            st           <= IDLE;
          end
        end
        I_REQ: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            if (bus_data_ok) begin
              inst_rdata_r <= bus_rdata;
              inst_done    <= 1'b1;
              st           <= IDLE;
            end else begin
              st <= I_WAIT;
            end
          end
        end
        I_WAIT: begin
          if (bus_data_ok) begin
            inst_rdata_r <= bus_rdata;
            inst_done    <= 1'b1;
            st           <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable bus slave plus one
// task per scenario with inline comparisons against hand-computed values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        ext_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int tests = 0;
  int fails = 0;

  // slave model controls
  bit          slave_en  = 1'b1;
  int          aw_wait   = 0;
  int          dw_wait   = 0;
  bit          together  = 1'b0;
  logic [31:0] rd_val    = 32'h0;
  int          hs        = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
    .ext_stall(ext_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  // Slave: addr_ok after aw_wait cycles of bus_req, data_ok dw_wait cycles later
  // (or in the accepting cycle when together is set).
  initial begin
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    forever begin
      @(posedge clk);
      if (bus_req && bus_addr_ok) begin
        hs++;
        if (bus_data_ok) ph = 0;
        else begin ph = 2; cnt = 0; end
      end else if (ph == 2 && bus_data_ok) begin
        ph = 0;
      end else if (ph != 0) begin
        cnt++;
      end
      #1;
      if (slave_en) begin
        if (!resetn) begin
          ph = 0;
          bus_addr_ok = 1'b0;
          bus_data_ok = 1'b0;
        end else begin
          if (ph == 0 && bus_req) begin ph = 1; cnt = 0; end
          bus_addr_ok = (ph == 1) && (cnt >= aw_wait);
          bus_data_ok = ((ph == 2) && (cnt >= dw_wait)) || ((ph == 1) && bus_addr_ok && together);
          bus_rdata   = rd_val;
        end
      end else begin
        ph = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_req = 1'b1;
    inst_addr = 32'hBFC0_0000;
    rd_val = 32'h0000_0055;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req: got %b exp 0", bus_req); end
      tests++; if (i_stall !== 1'b1) begin fails++; $display("FAIL reset_i_stall: got %b exp 1", i_stall); end
      tests++; if (inst_rdata !== 32'h0) begin fails++; $display("FAIL reset_inst_rdata: got %h exp 0", inst_rdata); end
      tests++; if (data_rdata !== 32'h0) begin fails++; $display("FAIL reset_data_rdata: got %h exp 0", data_rdata); end
    end
    resetn = 1'b1;
    #1;
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL reset_rel_cycle1: got %b exp 0", bus_req); end
    tick();
    tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL reset_rel_cycle2: got %b exp 1", bus_req); end
    for (int n = 0; n < 20 && i_stall; n++) tick();
    tests++; if (inst_rdata !== 32'h0000_0055) begin fails++; $display("FAIL reset_first_fetch: got %h exp 00000055", inst_rdata); end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    int n;
    n = 0;
    rd_val = 32'h2408_0001;
    inst_addr = 32'hBFC0_0000;
    inst_req = 1'b1;
    #1;
    while (i_stall && n < 30) begin
      n++;
      if (bus_req) begin
        tests++; if (bus_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL fetch_bus_addr: got %h exp bfc00000", bus_addr); end
        tests++; if (bus_size !== 2'd2) begin fails++; $display("FAIL fetch_bus_size: got %0d exp 2", bus_size); end
        tests++; if (bus_wr !== 1'b0) begin fails++; $display("FAIL fetch_bus_wr: got %b exp 0", bus_wr); end
      end
      tick();
    end
    tests++; if (n !== 3) begin fails++; $display("FAIL fetch_stall_cycles: got %0d exp 3", n); end
    tests++; if (inst_rdata !== 32'h2408_0001) begin fails++; $display("FAIL fetch_rdata: got %h exp 24080001", inst_rdata); end
    inst_req = 1'b0;
    tick();
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL fetch_no_reissue: got %b exp 0", bus_req); end
  endtask

  task automatic test_data_priority();
    int n;
    int nd;
    int hs0;
    bit first;
    n = 0;
    nd = 0;
    first = 1'b1;
    hs0 = hs;
    rd_val = 32'h0000_1234;
    inst_addr = 32'hBFC0_0004;
    data_addr = 32'h8000_0010;
    data_size = 2'd0;
    data_wr = 1'b1;
    data_wdata = 32'h0000_00AB;
    inst_req = 1'b1;
    data_req = 1'b1;
    #1;
    while (i_stall && n < 30) begin
      n++;
      if (d_stall) nd++;
      if (bus_req && first) begin
        first = 1'b0;
        tests++; if (bus_wr !== 1'b1) begin fails++; $display("FAIL prio_first_wr: got %b exp 1", bus_wr); end
        tests++; if (bus_size !== 2'd0) begin fails++; $display("FAIL prio_first_size: got %0d exp 0", bus_size); end
        tests++; if (bus_addr !== 32'h8000_0010) begin fails++; $display("FAIL prio_first_addr: got %h exp 80000010", bus_addr); end
        tests++; if (bus_wdata !== 32'h0000_00AB) begin fails++; $display("FAIL prio_first_wdata: got %h exp 000000ab", bus_wdata); end
      end
      tick();
    end
    tests++; if (nd !== 3) begin fails++; $display("FAIL prio_d_stall_cycles: got %0d exp 3", nd); end
    tests++; if (n !== 6) begin fails++; $display("FAIL prio_i_stall_cycles: got %0d exp 6", n); end
    tests++; if (inst_rdata !== 32'h0000_1234) begin fails++; $display("FAIL prio_inst_rdata: got %h exp 00001234", inst_rdata); end
    inst_req = 1'b0;
    data_req = 1'b0;
    data_wr = 1'b0;
    tick();
    tests++; if (hs - hs0 !== 2) begin fails++; $display("FAIL prio_handshakes: got %0d exp 2", hs - hs0); end
  endtask

  task automatic test_ext_stall_hold();
    int n;
    int hs0;
    n = 0;
    hs0 = hs;
    rd_val = 32'hCAFE_F00D;
    data_addr = 32'h8000_0020;
    data_size = 2'd2;
    data_wr = 1'b0;
    data_req = 1'b1;
    ext_stall = 1'b1;
    #1;
    while (d_stall && n < 30) begin n++; tick(); end
    tests++; if (n !== 3) begin fails++; $display("FAIL ext_load_cycles: got %0d exp 3", n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (d_stall !== 1'b0) begin fails++; $display("FAIL ext_hold_d_stall: got %b exp 0", d_stall); end
      tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL ext_hold_bus_req: got %b exp 0", bus_req); end
      tests++; if (data_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL ext_hold_rdata: got %h exp cafef00d", data_rdata); end
      tick();
    end
    tests++; if (hs - hs0 !== 1) begin fails++; $display("FAIL ext_hold_handshakes: got %0d exp 1", hs - hs0); end
    ext_stall = 1'b0;
    tick();
    tests++; if (d_stall !== 1'b1) begin fails++; $display("FAIL ext_done_cleared: got %b exp 1", d_stall); end
    data_req = 1'b0;
    tick();
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL ext_no_reissue: got %b exp 0", bus_req); end
  endtask

  task automatic test_wait_states();
    int n;
    int nb;
    logic [31:0] a0;
    n = 0;
    nb = 0;
    aw_wait = 3;
    dw_wait = 5;
    rd_val = 32'h1122_3344;
    data_addr = 32'h8000_0040;
    data_size = 2'd1;
    data_wr = 1'b0;
    data_req = 1'b1;
    #1;
    while (d_stall && n < 40) begin
      n++;
      if (bus_req) begin
        nb++;
        if (nb == 1) a0 = bus_addr;
        tests++; if (bus_addr !== 32'h8000_0040 || bus_size !== 2'd1) begin fails++; $display("FAIL wait_fields_stable: got %h/%0d exp 80000040/1", bus_addr, bus_size); end
      end
      tick();
    end
    tests++; if (nb !== 4) begin fails++; $display("FAIL wait_bus_req_cycles: got %0d exp 4", nb); end
    tests++; if (n !== 11) begin fails++; $display("FAIL wait_d_stall_cycles: got %0d exp 11", n); end
    tests++; if (data_rdata !== 32'h1122_3344) begin fails++; $display("FAIL wait_rdata: got %h exp 11223344", data_rdata); end
    data_req = 1'b0;
    aw_wait = 0;
    dw_wait = 0;
    tick();
  endtask

  task automatic test_back_to_back_ok();
    int n;
    n = 0;
    together = 1'b1;
    rd_val = 32'h5A5A_0F0F;
    data_addr = 32'h8000_0080;
    data_size = 2'd2;
    data_req = 1'b1;
    #1;
    while (d_stall && n < 30) begin n++; tick(); end
    tests++; if (n !== 2) begin fails++; $display("FAIL together_cycles: got %0d exp 2", n); end
    tests++; if (data_rdata !== 32'h5A5A_0F0F) begin fails++; $display("FAIL together_rdata: got %h exp 5a5a0f0f", data_rdata); end
    data_req = 1'b0;
    together = 1'b0;
    tick();
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL together_idle: got %b exp 0", bus_req); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    slave_en = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    data_addr = 32'h8000_0100;
    data_size = 2'd2;
    data_req = 1'b1;
    #1;
    tick();
    tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL rstw_req: got %b exp 1", bus_req); end
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    #1;
    tests++; if (d_stall !== 1'b1 || bus_req !== 1'b0) begin fails++; $display("FAIL rstw_in_wait: got d_stall=%b bus_req=%b exp 1/0", d_stall, bus_req); end
    resetn = 1'b0;
    data_req = 1'b0;
    tick();
    resetn = 1'b1;
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL rstw_bus_req: got %b exp 0", bus_req); end
    bus_data_ok = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_data_ok = 1'b0;
    tests++; if (data_rdata !== 32'h0) begin fails++; $display("FAIL rstw_no_capture: got %h exp 0", data_rdata); end
    data_req = 1'b1;
    #1;
    tests++; if (d_stall !== 1'b1) begin fails++; $display("FAIL rstw_done_clear: got %b exp 1", d_stall); end
    tests++; if (bus_req !== 1'b0) begin fails++; $display("FAIL rstw_not_issued_yet: got %b exp 0", bus_req); end
    tick();
    tests++; if (bus_req !== 1'b1) begin fails++; $display("FAIL rstw_idle_reissue: got %b exp 1", bus_req); end
    rd_val = 32'h0BAD_F00D;
    slave_en = 1'b1;
    n = 0;
    while (d_stall && n < 30) begin n++; tick(); end
    tests++; if (data_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL rstw_recover: got %h exp 0badf00d", data_rdata); end
    data_req = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0;
    inst_addr = 32'h0;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_size = 2'd0;
    data_addr = 32'h0;
    data_wdata = 32'h0;
    ext_stall = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata = 32'h0;
    #1;
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_ext_stall_hold();
    test_wait_states();
    test_back_to_back_ok();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
